// File: rtl/lcd_stream_ctrl.sv
// HD44780-class character LCD controller: self-run power-up init, byte FIFO,
// cursor tracking with automatic line-change commands, timer-paced bus writes.
module lcd_stream_ctrl #(
   parameter int FIFO_DEPTH   = 16,
   parameter int COLS         = 16,
   parameter int EN_CYCLES    = 25,
   parameter int CMD_CYCLES   = 2500,
   parameter int CLR_CYCLES   = 100000,
   parameter int PWRUP_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [8:0] wr_data,
   output logic       full,
   output logic       busy,
   output logic       ovf,
   output logic [7:0] LCD,
   output logic       lcdRS,
   output logic       lcdRW,
   output logic       lcdEn,
   output logic [2:0] dbgState
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = $clog2(COLS);
   localparam int MAX_A = (PWRUP_CYCLES > CLR_CYCLES) ? PWRUP_CYCLES : CLR_CYCLES;
   localparam int MAX_B = (CMD_CYCLES > EN_CYCLES) ? CMD_CYCLES : EN_CYCLES;
   localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int TW    = $clog2(MAX_T + 1);

   localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
   localparam logic [CW-1:0] COL_ONE   = CW'(1);
   localparam logic [TW-1:0] TMR_ONE   = TW'(1);
   localparam logic [TW-1:0] PWR_LAST  = TW'(PWRUP_CYCLES - 1);
   localparam logic [TW-1:0] EN_LAST   = TW'(EN_CYCLES - 1);
   localparam logic [TW-1:0] CMD_LAST  = TW'(CMD_CYCLES - 1);
   localparam logic [TW-1:0] CLR_LAST  = TW'(CLR_CYCLES - 1);
   localparam logic [5:0]    COL_LAST6 = 6'(COLS - 1);

   typedef enum logic [2:0] {
      PWRUP = 3'd0,
      SETUP = 3'd1,
      PULSE = 3'd2,
      WAIT  = 3'd3,
      WRAP  = 3'd4,
      IDLE  = 3'd5
   } state_t;

   state_t        state, stateNext;
   logic [TW-1:0] timer, timerNext;
   logic          initMode, initNext;
   logic [2:0]    initIdx, idxNext;
   logic [CW-1:0] col, colNext;
   logic          line, lineNext;
   logic          loadBus;
   logic [8:0]    busNext;
   logic          wrapHit;

   // FIFO
   logic [8:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wrPtr, rdPtr;
   logic [AW:0]   count, countNext;
   logic          pushOk, popOk;

   // Write port: a push is taken on any cycle wr_en=1 while full=0; a push
   // seen while full=1 is discarded and latches ovf. There is no back-pressure.
   assign pushOk = wr_en && !full;
   assign popOk  = (state == IDLE) && (count != '0);

   always_comb begin
      countNext = count;
      unique case ({pushOk, popOk})
         2'b10:   countNext = count + CNT_ONE;
         2'b01:   countNext = count - CNT_ONE;
         default: countNext = count;
      endcase
   end

   function automatic logic [7:0] initByte(input logic [2:0] idx);
      unique case (idx)
         3'd0, 3'd1, 3'd2: initByte = 8'h38;
         3'd3:             initByte = 8'h0C;
         3'd4:             initByte = 8'h01;
         default:          initByte = 8'h06;
      endcase
   endfunction

   // Clear/home commands need the long settle time; characters never do.
   logic          isClr;
   logic [TW-1:0] waitLast;
   logic [5:0]    tgtCol;
   logic [CW-1:0] colSat;

   assign isClr    = !lcdRS && ((LCD == 8'h01) || (LCD == 8'h02));
   assign waitLast = isClr ? CLR_LAST : CMD_LAST;
   assign tgtCol   = LCD[5:0];
   assign colSat   = (tgtCol >= COL_LAST6) ? COL_LAST : CW'(tgtCol);

   always_comb begin
      stateNext = state;
      timerNext = timer + TMR_ONE;
      initNext  = initMode;
      idxNext   = initIdx;
      colNext   = col;
      lineNext  = line;
      loadBus   = 1'b0;
      busNext   = {lcdRS, LCD};
      wrapHit   = 1'b0;
      unique case (state)
         PWRUP: begin
            if (timer == PWR_LAST) begin
               stateNext = SETUP;
               timerNext = '0;
               initNext  = 1'b1;
               idxNext   = 3'd0;
               loadBus   = 1'b1;
               busNext   = {1'b0, initByte(3'd0)};
            end
         end
         SETUP: begin
            stateNext = PULSE;
            timerNext = '0;
         end
         PULSE: begin
            if (timer == EN_LAST) begin
               stateNext = WAIT;
               timerNext = '0;
            end
         end
         WAIT: begin
            if (timer == waitLast) begin
               timerNext = '0;
               if (lcdRS) begin
                  if (col == COL_LAST) begin
                     colNext  = '0;
                     lineNext = ~line;
                     wrapHit  = 1'b1;
                  end else begin
                     colNext = col + COL_ONE;
                  end
               end else if (isClr) begin
                  colNext  = '0;
                  lineNext = 1'b0;
               end else if (LCD[7]) begin
                  lineNext = LCD[6];
                  colNext  = colSat;
               end
               if (initMode) begin
                  if (initIdx == 3'd5) begin
                     initNext  = 1'b0;
                     stateNext = IDLE;
                  end else begin
                     idxNext   = initIdx + 3'd1;
                     stateNext = SETUP;
                     loadBus   = 1'b1;
                     busNext   = {1'b0, initByte(initIdx + 3'd1)};
                  end
               end else if (wrapHit) begin
                  stateNext = WRAP;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         WRAP: begin
            // line already holds the new line, so it picks the DDRAM row.
            stateNext = SETUP;
            timerNext = '0;
            loadBus   = 1'b1;
            busNext   = {1'b0, (line ? 8'hC0 : 8'h80)};
         end
         IDLE: begin
            timerNext = '0;
            if (count != '0) begin
               stateNext = SETUP;
               loadBus   = 1'b1;
               busNext   = mem[rdPtr];
            end
         end
         default: begin
            stateNext = PWRUP;
            timerNext = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= PWRUP;
         timer    <= '0;
         initMode <= 1'b0;
         initIdx  <= 3'd0;
         col      <= '0;
         line     <= 1'b0;
         LCD      <= 8'h00;
         lcdRS    <= 1'b0;
         lcdEn    <= 1'b0;
         busy     <= 1'b1;
         full     <= 1'b0;
         ovf      <= 1'b0;
         count    <= '0;
         wrPtr    <= '0;
         rdPtr    <= '0;
      end else begin
         state    <= stateNext;
         timer    <= timerNext;
         initMode <= initNext;
         initIdx  <= idxNext;
         col      <= colNext;
         line     <= lineNext;
         if (loadBus) begin
            lcdRS <= busNext[8];
            LCD   <= busNext[7:0];
         end
         lcdEn <= (stateNext == PULSE);
         busy  <= !((stateNext == IDLE) && (countNext == '0));
         full  <= (countNext == FULL_CNT);
         ovf   <= ovf | (wr_en & full);
         count <= countNext;
         if (pushOk) wrPtr <= wrPtr + PTR_ONE;
         if (popOk)  rdPtr <= rdPtr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (pushOk) mem[wrPtr] <= wr_data;
   end

   assign lcdRW    = 1'b0;
   assign dbgState = state;

endmodule

// File: tb/tb_lcd_stream_ctrl.sv
// Self-checking bench for lcd_stream_ctrl: a monitor decodes every enable
// strobe and compares it with a bus-write queue built from cursor rules.
module tb_lcd_stream_ctrl;

   localparam int DEPTH = 4;
   localparam int NCOLS = 4;
   localparam int EN    = 2;
   localparam int CMD   = 4;
   localparam int CLR   = 8;
   localparam int PWR   = 10;
   localparam int INIT_CYCLES = PWR + 5*(1+EN+CMD) + (1+EN+CLR);

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr_en = 1'b0;
   logic [8:0] wr_data = 9'h000;
   logic       full, busy, ovf, lcdRS, lcdRW, lcdEn;
   logic [7:0] LCD;
   logic [2:0] dbgState;

   lcd_stream_ctrl #(
      .FIFO_DEPTH(DEPTH), .COLS(NCOLS), .EN_CYCLES(EN), .CMD_CYCLES(CMD),
      .CLR_CYCLES(CLR), .PWRUP_CYCLES(PWR)
   ) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .busy(busy), .ovf(ovf), .LCD(LCD), .lcdRS(lcdRS),
      .lcdRW(lcdRW), .lcdEn(lcdEn), .dbgState(dbgState)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic [8:0] exp_q[$];
   int m_col = 0;
   int m_line = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int wait_for(input logic [8:0] w);
      return (!w[8] && (w[7:0] == 8'h01 || w[7:0] == 8'h02)) ? CLR : CMD;
   endfunction

   // reference model: what the bus must show for each accepted FIFO entry
   task automatic model_entry(input logic [8:0] d);
      exp_q.push_back(d);
      if (d[8]) begin
         if (m_col == NCOLS-1) begin
            m_col = 0;
            m_line = 1 - m_line;
            exp_q.push_back({1'b0, (m_line == 1) ? 8'hC0 : 8'h80});
         end else begin
            m_col++;
         end
      end else if (d[7:0] == 8'h01 || d[7:0] == 8'h02) begin
         m_col = 0;
         m_line = 0;
      end else if (d[7]) begin
         m_line = int'(d[6]);
         m_col = (int'(d[5:0]) > NCOLS-1) ? NCOLS-1 : int'(d[5:0]);
      end
   endtask

   // driver tasks (called at a negedge, return at a negedge)
   task automatic push(input logic [8:0] d, input bit acc);
      wr_en = 1'b1;
      wr_data = d;
      if (acc) model_entry(d);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", busy, 0);
   endtask

   task automatic hold_reset();
      reset = 1'b0;
      exp_q.delete();
      m_col = 0;
      m_line = 0;
      repeat (3) @(negedge clk);
      exp_q.push_back(9'h038);
      exp_q.push_back(9'h038);
      exp_q.push_back(9'h038);
      exp_q.push_back(9'h00C);
      exp_q.push_back(9'h001);
      exp_q.push_back(9'h006);
   endtask

   task automatic release_and_time();
      int n = 0;
      reset = 1'b1;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("init_cycles", n, INIT_CYCLES);
   endtask

   function automatic logic [8:0] rand_entry();
      int r = $urandom_range(0, 7);
      if (r < 5) return {1'b1, 8'($urandom_range(8'h20, 8'h7E))};
      if (r == 5) return {1'b0, 8'($urandom_range(1, 2))};
      if (r == 6) return {1'b0, 8'h80 | 8'($urandom_range(0, 127))};
      return {1'b0, 8'($urandom_range(3, 127))};
   endfunction

   // scoreboard / bus monitor
   logic       mon_prev_en = 1'b0;
   logic [8:0] mon_prev_bus = 9'h000;
   logic [8:0] mon_last = 9'h000;
   bit         mon_have = 1'b0;
   int         mon_gap = 0;
   int         mon_width = 0;

   always @(negedge clk) begin
      if (!reset) begin
         mon_prev_en = 1'b0;
         mon_prev_bus = 9'h000;
         mon_have = 1'b0;
         mon_gap = 0;
         mon_width = 0;
      end else begin
         if (lcdEn) begin
            if (!mon_prev_en) begin
               check("setup_valid", {lcdRS, LCD}, mon_prev_bus);
               if (mon_have) check("post_wait", (mon_gap >= wait_for(mon_last) + 1), 1);
               check("write_expected", (exp_q.size() > 0), 1);
               if (exp_q.size() > 0) check("bus", {lcdRS, LCD}, exp_q.pop_front());
               mon_last = {lcdRS, LCD};
               mon_have = 1'b1;
               mon_width = 0;
            end
            mon_width++;
         end else begin
            if (mon_prev_en) begin
               check("en_width", mon_width, EN);
               mon_gap = 0;
            end
            mon_gap++;
            if (mon_have && mon_gap <= wait_for(mon_last))
               check("bus_hold", {lcdRS, LCD}, mon_last);
         end
         mon_prev_en = lcdEn;
         mon_prev_bus = {lcdRS, LCD};
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [8:0] d;

      // reset values and init sequence timing
      @(negedge clk);
      hold_reset();
      check("rst_lcd", LCD, 8'h00);
      check("rst_rs", lcdRS, 0);
      check("rst_rw", lcdRW, 0);
      check("rst_en", lcdEn, 0);
      check("rst_full", full, 0);
      check("rst_ovf", ovf, 0);
      check("rst_busy", busy, 1);
      release_and_time();

      // single character: push edge, pop, setup, pulse, wait, then idle
      push(9'h141, 1'b1);
      n = 1;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("char_busy_cycles", n, 3 + EN + CMD);

      // auto wrap from column 0: A..I
      push(9'h080, 1'b1);
      wait_idle(100);
      for (int i = 0; i < 9; i++) begin
         push({1'b1, 8'h41 + 8'(i)}, 1'b1);
         if (i % 3 == 2) wait_idle(200);
      end
      wait_idle(200);
      check("wrap_drained", exp_q.size(), 0);

      // clear resets the cursor; wrap follows the 4th character after it
      push(9'h141, 1'b1);
      push(9'h142, 1'b1);
      push(9'h001, 1'b1);
      push(9'h143, 1'b1);
      wait_idle(200);
      for (int i = 0; i < 4; i++) push({1'b1, 8'h44 + 8'(i)}, 1'b1);
      wait_idle(200);
      check("clear_drained", exp_q.size(), 0);

      // randomized bursts, never more than DEPTH outstanding
      for (int b = 0; b < 30; b++) begin
         n = $urandom_range(1, DEPTH);
         for (int k = 0; k < n; k++) begin
            d = rand_entry();
            push(d, 1'b1);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
         end
         wait_idle(400);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      check("random_drained", exp_q.size(), 0);

      // overflow during power-up wait
      hold_reset();
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1;
         wr_data = {1'b1, 8'h50 + 8'(i)};
         if (i < DEPTH) model_entry(wr_data);
         @(negedge clk);
         check("full_after_push", full, (i >= DEPTH-1));
         check("ovf_after_push", ovf, (i >= DEPTH));
      end
      wr_en = 1'b0;
      wait_idle(400);
      check("ovf_sticky", ovf, 1);
      check("ovf_drained", exp_q.size(), 0);

      // reset in the middle of an enable pulse
      for (int i = 0; i < DEPTH; i++) push({1'b1, 8'h61 + 8'(i)}, 1'b1);
      n = 0;
      while (!lcdEn && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("en_seen", lcdEn, 1);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_en", lcdEn, 0);
      check("mid_rst_lcd", LCD, 8'h00);
      check("mid_rst_ovf", ovf, 0);
      check("mid_rst_full", full, 0);
      check("mid_rst_busy", busy, 1);
      @(negedge clk);
      hold_reset();
      release_and_time();
      repeat (20) @(negedge clk);
      check("flushed_busy", busy, 0);
      check("final_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
